// File: rtl/lcd_rx_monitor.sv
// Receive-side monitor for a parallel RGB LCD link: rebuilds pixel coordinates,
// measures and locks to frame geometry, flags timing errors and captures a probe pixel.
module lcd_rx_monitor #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    input  logic [10:0] probe_x,
    input  logic [10:0] probe_y,
    input  logic        clr_err,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] h_len,
    output logic [10:0] h_total,
    output logic [10:0] v_lines,
    output logic [23:0] probe_data,
    output logic        probe_hit,
    output logic        err_geom,
    output logic        err_de_vsync
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] CNT_MAX = 11'd2047;
    localparam logic [10:0] H_ACT_C = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_C = 11'(V_ACTIVE);

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 11'd1;
    endfunction

    state_t      state_r;
    logic [23:0] rgb_s1_r;
    logic        hs_act_s1_r, hs_act_s2_r;
    logic        vs_act_s1_r, vs_act_s2_r;
    logic        de_s1_r;
    logic        de_q2_r;
    logic [10:0] x_cnt_r;
    logic [10:0] y_cnt_r;
    logic [10:0] h_cnt_r;
    logic [10:0] shadow_x_r, shadow_y_r;
    logic        probe_pend_r;

    logic        hs_lead_s, vs_lead_s;
    logic        de_q1_s, de_rise_s, de_fall_s;
    logic [10:0] x_next_s;
    logic        pix_ok_s, probe_match_s;
    logic        geom_ok_s, geom_bad_s, de_vs_err_s;

    // Edge detection, column stepping and capture qualification
    always_comb begin
        hs_lead_s     = hs_act_s1_r & ~hs_act_s2_r;
        vs_lead_s     = vs_act_s1_r & ~vs_act_s2_r;
        // DE is only honoured outside vsync; a DE inside vsync never forms a line
        de_q1_s       = de_s1_r & ~vs_act_s1_r;
        de_rise_s     = de_q1_s & ~de_q2_r;
        de_fall_s     = ~de_q1_s & de_q2_r;
        if (de_rise_s) begin
            x_next_s = 11'd0;
        end else begin
            x_next_s = sat_inc(x_cnt_r);
        end
        pix_ok_s      = de_q1_s & (state_r != ST_SEARCH);
        probe_match_s = pix_ok_s & (x_next_s == shadow_x_r) & (y_cnt_r == shadow_y_r);
        geom_ok_s     = (y_cnt_r == V_ACT_C) & (h_len == H_ACT_C);
        geom_bad_s    = vs_lead_s & (state_r != ST_SEARCH) & ~geom_ok_s;
        de_vs_err_s   = de_s1_r & vs_act_s1_r;
    end

    // Input stages, syncs normalised to "active" level
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_s1_r    <= 24'd0;
            hs_act_s1_r <= 1'b0;
            hs_act_s2_r <= 1'b0;
            vs_act_s1_r <= 1'b0;
            vs_act_s2_r <= 1'b0;
            de_s1_r     <= 1'b0;
            de_q2_r     <= 1'b0;
        end else begin
            rgb_s1_r    <= rgb_in;
            hs_act_s1_r <= hsync_in ~^ SYNC_POL;
            hs_act_s2_r <= hs_act_s1_r;
            vs_act_s1_r <= vsync_in ~^ SYNC_POL;
            vs_act_s2_r <= vs_act_s1_r;
            de_s1_r     <= de_in;
            de_q2_r     <= de_q1_s;
        end
    end

    // Coordinate counters, line length and line period measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_r <= 11'd0;
            y_cnt_r <= 11'd0;
            h_cnt_r <= 11'd0;
            h_len   <= 11'd0;
            h_total <= 11'd0;
        end else begin
            if (de_q1_s) begin
                x_cnt_r <= x_next_s;
            end
            if (de_fall_s) begin
                h_len <= sat_inc(x_cnt_r);
            end
            if (vs_lead_s) begin
                y_cnt_r <= 11'd0;
            end else if (de_fall_s) begin
                y_cnt_r <= sat_inc(y_cnt_r);
            end
            // Counter restarts at 1 so the latched value equals the edge-to-edge distance
            if (hs_lead_s) begin
                h_total <= h_cnt_r;
                h_cnt_r <= 11'd1;
            end else begin
                h_cnt_r <= sat_inc(h_cnt_r);
            end
        end
    end

    // Pixel output register, probe shadowing and capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid    <= 1'b0;
            pix_x        <= 11'd0;
            pix_y        <= 11'd0;
            pix_data     <= 24'd0;
            shadow_x_r   <= 11'd0;
            shadow_y_r   <= 11'd0;
            probe_data   <= 24'd0;
            probe_pend_r <= 1'b0;
            probe_hit    <= 1'b0;
            err_de_vsync <= 1'b0;
        end else begin
            pix_valid <= pix_ok_s;
            if (pix_ok_s) begin
                pix_x    <= x_next_s;
                pix_y    <= y_cnt_r;
                pix_data <= rgb_s1_r;
            end
            if (vs_lead_s) begin
                shadow_x_r <= probe_x;
                shadow_y_r <= probe_y;
            end
            if (probe_match_s) begin
                probe_data <= rgb_s1_r;
            end
            probe_pend_r <= probe_match_s;
            probe_hit    <= probe_pend_r;
            err_de_vsync <= (err_de_vsync & ~clr_err) | de_vs_err_s;
        end
    end

    // Lock FSM: geometry of each completed frame judged at the vsync leading edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_SEARCH;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            v_lines     <= 11'd0;
            err_geom    <= 1'b0;
        end else begin
            frame_start <= vs_lead_s;
            err_geom    <= (err_geom & ~clr_err) | geom_bad_s;
            if (vs_lead_s) begin
                case (state_r)
                    ST_SEARCH: begin
                        state_r <= ST_SYNC;
                        locked  <= 1'b0;
                    end
                    ST_SYNC: begin
                        v_lines <= y_cnt_r;
                        if (geom_ok_s) begin
                            state_r <= ST_LOCKED;
                            locked  <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        v_lines <= y_cnt_r;
                        if (!geom_ok_s) begin
                            state_r <= ST_SYNC;
                            locked  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_SEARCH;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Randomized bench for lcd_rx_monitor on a scaled-down raster, checked against a
// frame-level reference model (pixel queue, probe queue, geometry/lock/error rules).
module tb_lcd_rx_monitor;

    localparam int H_ACT   = 16;
    localparam int V_ACT   = 6;
    localparam int H_TOT   = 24;
    localparam int H_START = 4;
    localparam int V_TOT   = 10;
    localparam int V_FIRST = 3;
    localparam int NF      = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] rgb_in;
    logic        hsync_in, vsync_in, de_in;
    logic [10:0] probe_x, probe_y;
    logic        clr_err;
    logic [10:0] pix_x, pix_y, h_len, h_total, v_lines;
    logic [23:0] pix_data, probe_data;
    logic        pix_valid, frame_start, locked, probe_hit, err_geom, err_de_vsync;

    lcd_rx_monitor #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .SYNC_POL(1'b0)) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .probe_x(probe_x), .probe_y(probe_y), .clr_err(clr_err),
        .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked), .h_len(h_len), .h_total(h_total),
        .v_lines(v_lines), .probe_data(probe_data), .probe_hit(probe_hit),
        .err_geom(err_geom), .err_de_vsync(err_de_vsync)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model state
    bit          seen_edge, locked_exp, err_geom_exp, err_dv_exp, pend_geom, pend_dv;
    bit          prev_hs, prev_vs, prev_de;
    int          lines_cnt, cur_len, last_len, v_lines_exp, hs_edges, edge_cnt, fs_seen;
    logic [10:0] sh_x, sh_y;
    logic [45:0] pix_q[$];
    logic [23:0] probe_q[$];
    logic [45:0] mon_e;
    logic [23:0] mon_p;

    task automatic model_reset();
        seen_edge = 1'b0; locked_exp = 1'b0; err_geom_exp = 1'b0; err_dv_exp = 1'b0;
        pend_geom = 1'b0; pend_dv = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0; prev_de = 1'b0;
        lines_cnt = 0; cur_len = 0; last_len = 0; v_lines_exp = 0; hs_edges = 0;
        sh_x = 11'd0; sh_y = 11'd0;
        pix_q.delete();
        probe_q.delete();
    endtask

    task automatic drive_cyc(input bit hs, input bit vs, input bit de, input logic [23:0] rgb,
                             input bit clr, input bit rs);
        bit good;
        bit de_eff;
        rst = rs; hsync_in = ~hs; vsync_in = ~vs; de_in = de; rgb_in = rgb; clr_err = clr;
        de_eff = de && !vs;
        err_geom_exp = (err_geom_exp && !clr) || pend_geom;
        err_dv_exp   = (err_dv_exp && !clr) || pend_dv;
        pend_geom = 1'b0;
        pend_dv   = de && vs;
        if (hs && !prev_hs) hs_edges++;
        if (vs && !prev_vs) begin
            edge_cnt++;
            if (seen_edge) begin
                v_lines_exp = lines_cnt;
                good = (lines_cnt == V_ACT) && (last_len == H_ACT);
                locked_exp = good;
                pend_geom = !good;
            end
            seen_edge = 1'b1;
            lines_cnt = 0;
            sh_x = probe_x;
            sh_y = probe_y;
        end
        if (de_eff) begin
            if (seen_edge) begin
                pix_q.push_back({11'(cur_len), 11'(lines_cnt), rgb});
                if (11'(cur_len) == sh_x && 11'(lines_cnt) == sh_y) probe_q.push_back(rgb);
            end
            cur_len++;
        end else if (prev_de) begin
            last_len = cur_len;
            lines_cnt++;
            cur_len = 0;
        end
        prev_hs = hs; prev_vs = vs; prev_de = de_eff;
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
            check_val("rst_pix",   32'({pix_valid, pix_x, pix_y}), 32'd0);
            check_val("rst_data",  32'(pix_data), 32'd0);
            check_val("rst_flags", 32'({frame_start, locked, probe_hit, err_geom, err_de_vsync}), 32'd0);
            check_val("rst_hmeas", 32'({h_len, h_total}), 32'd0);
            check_val("rst_vlines", 32'(v_lines), 32'd0);
            check_val("rst_probe", 32'(probe_data), 32'd0);
        end
    endtask

    // Output monitor: pixels and probe captures popped from the model queues
    always @(negedge clk) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) begin
                check_val("pix_extra", 32'd1, 32'd0);
            end else begin
                mon_e = pix_q.pop_front();
                check_val("pix_xy", 32'({pix_x, pix_y}), 32'(mon_e[45:24]));
                check_val("pix_data", 32'(pix_data), 32'(mon_e[23:0]));
            end
        end
        if (probe_hit) begin
            if (probe_q.size() == 0) begin
                check_val("probe_extra", 32'd1, 32'd0);
            end else begin
                mon_p = probe_q.pop_front();
                check_val("probe_data", 32'(probe_data), 32'(mon_p));
            end
        end
        if (frame_start) fs_seen++;
    end

    initial begin
        bit short_last, miss, blip, pchg, clr_mid, rst_mid, hs, vs, de, clr, rs;
        int n_lines, act, len;
        edge_cnt = 0; fs_seen = 0;
        rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; rgb_in = 24'd0;
        clr_err = 1'b0;
        probe_x = 11'(H_ACT - 1);
        probe_y = 11'(V_ACT - 1);
        model_reset();
        for (int i = 0; i < 3; i++) drive_cyc(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b1);

        for (int f = 0; f < NF; f++) begin
            short_last = (f == 3) || (f >= 7 && $urandom_range(0, 4) == 0);
            miss       = !short_last && ((f == 8) || (f >= 9 && $urandom_range(0, 5) == 0));
            blip       = (f == 4) || (f >= 5 && $urandom_range(0, 3) == 0);
            pchg       = (f == 5) || (f >= 6 && $urandom_range(0, 2) == 0);
            clr_mid    = (f == 10) || (f >= 3 && $urandom_range(0, 2) == 0);
            rst_mid    = (f == NF / 2);
            if (f >= 6 && $urandom_range(0, 1) == 0) begin
                probe_x = 11'($urandom_range(0, H_ACT - 1));
                probe_y = 11'($urandom_range(0, V_ACT - 1));
            end
            n_lines = miss ? V_ACT - 1 : V_ACT;
            for (int ln = 0; ln < V_TOT; ln++) begin
                for (int c = 0; c < H_TOT; c++) begin
                    hs  = (c < 2);
                    vs  = (ln < 2);
                    act = ln - V_FIRST;
                    len = (short_last && act == n_lines - 1) ? H_ACT - 1 : H_ACT;
                    de  = (act >= 0) && (act < n_lines) && (c >= H_START) && (c < H_START + len);
                    if (blip && ln == 0 && c < 3) de = 1'b1;
                    clr = (blip && ln == 0 && c == 1) || (clr_mid && ln == 6 && c == 0);
                    rs  = rst_mid && ln == 5 && c == 10;
                    if (pchg && ln == 5 && c == 0) probe_y = 11'($urandom_range(0, V_ACT - 1));
                    drive_cyc(hs, vs, de, 24'($urandom), clr, rs);
                    if (ln == 0 && c == 4) begin
                        check_val("locked", 32'(locked), 32'(locked_exp));
                        check_val("err_geom", 32'(err_geom), 32'(err_geom_exp));
                        check_val("err_de_vsync", 32'(err_de_vsync), 32'(err_dv_exp));
                        check_val("v_lines", 32'(v_lines), 32'(v_lines_exp));
                        check_val("h_len", 32'(h_len), 32'(last_len));
                        if (hs_edges >= 2) check_val("h_total", 32'(h_total), 32'(H_TOT));
                    end
                end
            end
        end

        for (int i = 0; i < 8; i++) drive_cyc(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
        check_val("pix_missing", 32'(pix_q.size()), 32'd0);
        check_val("probe_missing", 32'(probe_q.size()), 32'd0);
        check_val("frame_starts", 32'(fs_seen), 32'(edge_cnt));
        check_val("final_errs", 32'({err_geom, err_de_vsync}), 32'({err_geom_exp, err_dv_exp}));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
